// File: rtl/anycore_l15_reqdecoder_pkg.sv
// ============================================================================
// Module : anycore_l15_reqdecoder_pkg
// Brief  : Shared FSM encoding, class indices and store-size mapping for the
//          Anycore -> L1.5 request decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

// Fallback encodings matching l15.h when that header is not part of the build.
`ifndef L15_PADDR_MASK
`define L15_PADDR_MASK 39:0
`endif
`ifndef L15_THREADID_MASK
`define L15_THREADID_MASK 0:0
`endif
`ifndef IMISS_RQ
`define IMISS_RQ 5'b10000
`endif
`ifndef LOAD_RQ
`define LOAD_RQ 5'b00000
`endif
`ifndef STORE_RQ
`define STORE_RQ 5'b00001
`endif
`ifndef MSG_DATA_SIZE_1B
`define MSG_DATA_SIZE_1B 3'b001
`endif
`ifndef MSG_DATA_SIZE_16B
`define MSG_DATA_SIZE_16B 3'b101
`endif
`ifndef MSG_DATA_SIZE_32B
`define MSG_DATA_SIZE_32B 3'b110
`endif

package anycore_l15_reqdecoder_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    typedef enum logic [1:0] {
        CLS_IF = 2'd0,
        CLS_LD = 2'd1,
        CLS_ST = 2'd2
    } req_class_e;

    // stsize 0..3 maps linearly onto MSG_DATA_SIZE_1B..8B.
    localparam logic [2:0] C_STSIZE_MSG_BASE = `MSG_DATA_SIZE_1B;

    function automatic logic [2:0] st_msg_size(input logic [1:0] stsize);
        return C_STSIZE_MSG_BASE + {1'b0, stsize};
    endfunction

endpackage

`default_nettype wire

// File: rtl/anycore_l15_stdata_fmt.sv
// ============================================================================
// Module : anycore_l15_stdata_fmt
// Brief  : Replicates store data across 64 bits by size, then optionally
//          byte-reverses it (macro ANYCORE_REQ_BYTESWAP_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module anycore_l15_stdata_fmt (
    input  logic [63:0] data_in,
    input  logic [1:0]  size,
    output logic [63:0] data_out
);

    logic [63:0] w_repl;

    always_comb begin
        w_repl = data_in;
        case (size)
            2'd0:    w_repl = {8{data_in[7:0]}};
            2'd1:    w_repl = {4{data_in[15:0]}};
            2'd2:    w_repl = {2{data_in[31:0]}};
            default: w_repl = data_in;
        endcase
    end

`ifdef ANYCORE_REQ_BYTESWAP_EN
    // Mirror of the swap the response encoder applies to returned data.
    for (genvar i = 0; i < 8; i++) begin : g_swap
        assign data_out[8*i +: 8] = w_repl[8*(7-i) +: 8];
    end
`else
    assign data_out = w_repl;
`endif

endmodule

`default_nettype wire

// File: rtl/anycore_l15_reqdecoder.sv
// ============================================================================
// Module : anycore_l15_reqdecoder
// Brief  : Captures Anycore ifill/load/store pulses, arbitrates ST > LD > IF
//          and issues one L1.5 request at a time. Option: ANYCORE_REQ_BYTESWAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef L15_PADDR_MASK
`define L15_PADDR_MASK 39:0
`endif
`ifndef L15_THREADID_MASK
`define L15_THREADID_MASK 0:0
`endif

module anycore_l15_reqdecoder
    import anycore_l15_reqdecoder_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      anycore_ic2mem_reqvalid,
    input  logic [`L15_PADDR_MASK]    anycore_ic2mem_reqaddr,
    input  logic                      anycore_dc2mem_ldvalid,
    input  logic [`L15_PADDR_MASK]    anycore_dc2mem_ldaddr,
    input  logic                      anycore_dc2mem_stvalid,
    input  logic [`L15_PADDR_MASK]    anycore_dc2mem_staddr,
    input  logic [63:0]               anycore_dc2mem_stdata,
    input  logic [1:0]                anycore_dc2mem_stsize,
    input  logic                      anycore_ifill_done,
    input  logic                      anycore_ld_done,
    input  logic                      anycore_st_done,
    output logic                      transducer_l15_val,
    output logic [4:0]                transducer_l15_rqtype,
    output logic [2:0]                transducer_l15_size,
    output logic [`L15_PADDR_MASK]    transducer_l15_address,
    output logic [63:0]               transducer_l15_data,
    output logic                      transducer_l15_nc,
    output logic [`L15_THREADID_MASK] transducer_l15_threadid,
    input  logic                      l15_transducer_ack,
    output logic                      anycore_req_overflow
);

    localparam int PADDR_W = $bits(anycore_ic2mem_reqaddr);
    localparam logic [PADDR_W-1:0] C_IF_MASK = ~PADDR_W'(5'h1f);
    localparam logic [PADDR_W-1:0] C_LD_MASK = ~PADDR_W'(4'hf);

    logic [0:0]         r_state;
    req_class_e         r_sel;
    logic               r_if_pend, r_ld_pend, r_st_pend;
    logic               r_if_out,  r_ld_out,  r_st_out;
    logic [PADDR_W-1:0] r_if_addr, r_ld_addr, r_st_addr;
    logic [63:0]        r_st_data;
    logic [1:0]         r_st_size;
    logic               r_val;
    logic [4:0]         r_rqtype;
    logic [2:0]         r_size;
    logic [PADDR_W-1:0] r_addr;
    logic [63:0]        r_data;
    logic               r_ovf;

    logic w_if_ovf, w_ld_ovf, w_st_ovf;
    logic w_if_cap, w_ld_cap, w_st_cap;
    logic w_acked, w_if_ack, w_ld_ack, w_st_ack;
    logic [63:0] w_st_fmt;

    // A request is dropped if its slot is full or its class is still in flight.
    assign w_if_ovf = anycore_ic2mem_reqvalid & (r_if_pend | (r_if_out & ~anycore_ifill_done));
    assign w_ld_ovf = anycore_dc2mem_ldvalid  & (r_ld_pend | (r_ld_out & ~anycore_ld_done));
    assign w_st_ovf = anycore_dc2mem_stvalid  & (r_st_pend | (r_st_out & ~anycore_st_done));

    assign w_if_cap = anycore_ic2mem_reqvalid & ~w_if_ovf;
    assign w_ld_cap = anycore_dc2mem_ldvalid  & ~w_ld_ovf;
    assign w_st_cap = anycore_dc2mem_stvalid  & ~w_st_ovf;

    assign w_acked  = (r_state == ST_REQ) & l15_transducer_ack;
    assign w_if_ack = w_acked & (r_sel == CLS_IF);
    assign w_ld_ack = w_acked & (r_sel == CLS_LD);
    assign w_st_ack = w_acked & (r_sel == CLS_ST);

    anycore_l15_stdata_fmt u_stdata_fmt (
        .data_in  (r_st_data),
        .size     (r_st_size),
        .data_out (w_st_fmt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= CLS_IF;
            r_if_pend <= 1'b0;
            r_ld_pend <= 1'b0;
            r_st_pend <= 1'b0;
            r_if_out  <= 1'b0;
            r_ld_out  <= 1'b0;
            r_st_out  <= 1'b0;
            r_if_addr <= '0;
            r_ld_addr <= '0;
            r_st_addr <= '0;
            r_st_data <= '0;
            r_st_size <= '0;
            r_val     <= 1'b0;
            r_rqtype  <= '0;
            r_size    <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_if_ovf | w_ld_ovf | w_st_ovf;

            // Capture and ack never coincide: capture needs an empty slot.
            if (w_if_cap) begin
                r_if_pend <= 1'b1;
                r_if_addr <= anycore_ic2mem_reqaddr;
            end else if (w_if_ack) begin
                r_if_pend <= 1'b0;
            end
            if (w_ld_cap) begin
                r_ld_pend <= 1'b1;
                r_ld_addr <= anycore_dc2mem_ldaddr;
            end else if (w_ld_ack) begin
                r_ld_pend <= 1'b0;
            end
            if (w_st_cap) begin
                r_st_pend <= 1'b1;
                r_st_addr <= anycore_dc2mem_staddr;
                r_st_data <= anycore_dc2mem_stdata;
                r_st_size <= anycore_dc2mem_stsize;
            end else if (w_st_ack) begin
                r_st_pend <= 1'b0;
            end

            r_if_out <= (r_if_out & ~anycore_ifill_done) | w_if_ack;
            r_ld_out <= (r_ld_out & ~anycore_ld_done)    | w_ld_ack;
            r_st_out <= (r_st_out & ~anycore_st_done)    | w_st_ack;

            case (r_state)
                ST_IDLE: begin
                    if (r_st_pend & ~r_st_out) begin
                        r_sel    <= CLS_ST;
                        r_rqtype <= `STORE_RQ;
                        r_size   <= st_msg_size(r_st_size);
                        r_addr   <= r_st_addr;
                        r_data   <= w_st_fmt;
                        r_val    <= 1'b1;
                        r_state  <= ST_REQ;
                    end else if (r_ld_pend & ~r_ld_out) begin
                        r_sel    <= CLS_LD;
                        r_rqtype <= `LOAD_RQ;
                        r_size   <= `MSG_DATA_SIZE_16B;
                        r_addr   <= r_ld_addr & C_LD_MASK;
                        r_data   <= '0;
                        r_val    <= 1'b1;
                        r_state  <= ST_REQ;
                    end else if (r_if_pend & ~r_if_out) begin
                        r_sel    <= CLS_IF;
                        r_rqtype <= `IMISS_RQ;
                        r_size   <= `MSG_DATA_SIZE_32B;
                        r_addr   <= r_if_addr & C_IF_MASK;
                        r_data   <= '0;
                        r_val    <= 1'b1;
                        r_state  <= ST_REQ;
                    end
                end
                default: begin
                    if (l15_transducer_ack) begin
                        r_val   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign transducer_l15_val      = r_val;
    assign transducer_l15_rqtype   = r_rqtype;
    assign transducer_l15_size     = r_size;
    assign transducer_l15_address  = r_addr;
    assign transducer_l15_data     = r_data;
    assign transducer_l15_nc       = 1'b0;
    assign transducer_l15_threadid = '0;
    assign anycore_req_overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_anycore_l15_reqdecoder.sv
// ============================================================================
// Module : tb_anycore_l15_reqdecoder
// Brief  : Directed self-checking bench for anycore_l15_reqdecoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef L15_PADDR_MASK
`define L15_PADDR_MASK 39:0
`endif
`ifndef L15_THREADID_MASK
`define L15_THREADID_MASK 0:0
`endif

module tb_anycore_l15_reqdecoder;

    localparam logic [4:0] C_IMISS = 5'b10000;
    localparam logic [4:0] C_LOAD  = 5'b00000;
    localparam logic [4:0] C_STORE = 5'b00001;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_valid, ld_valid, st_valid;
    logic [39:0] ic_addr, ld_addr, st_addr;
    logic [63:0] st_data;
    logic [1:0]  st_size;
    logic        if_done, ld_done, st_done;
    logic        val;
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [39:0] address;
    logic [63:0] data;
    logic        nc;
    logic [0:0]  threadid;
    logic        ack;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    anycore_l15_reqdecoder dut (
        .clk                     (clk),
        .rst                     (rst),
        .anycore_ic2mem_reqvalid (ic_valid),
        .anycore_ic2mem_reqaddr  (ic_addr),
        .anycore_dc2mem_ldvalid  (ld_valid),
        .anycore_dc2mem_ldaddr   (ld_addr),
        .anycore_dc2mem_stvalid  (st_valid),
        .anycore_dc2mem_staddr   (st_addr),
        .anycore_dc2mem_stdata   (st_data),
        .anycore_dc2mem_stsize   (st_size),
        .anycore_ifill_done      (if_done),
        .anycore_ld_done         (ld_done),
        .anycore_st_done         (st_done),
        .transducer_l15_val      (val),
        .transducer_l15_rqtype   (rqtype),
        .transducer_l15_size     (size),
        .transducer_l15_address  (address),
        .transducer_l15_data     (data),
        .transducer_l15_nc       (nc),
        .transducer_l15_threadid (threadid),
        .l15_transducer_ack      (ack),
        .anycore_req_overflow    (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ack_now();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("val_drop_after_ack", {63'd0, val}, 64'd1 - 64'd1);
    endtask

    // Store vectors: address, raw data, stsize, expected data, expected size.
    logic [39:0] sv_addr [4] = '{40'h100, 40'h203, 40'h404, 40'h808};
    logic [63:0] sv_data [4] = '{64'h10, 64'hFFFF_FFFF_FFFF_AABB,
                                 64'hDEAD_BEEF_1122_3344, 64'h0102_0304_0506_0708};
    logic [1:0]  sv_sz   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [2:0]  sv_msz  [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
`ifdef ANYCORE_REQ_BYTESWAP_EN
    logic [63:0] sv_exp  [4] = '{64'h1010_1010_1010_1010, 64'hBBAA_BBAA_BBAA_BBAA,
                                 64'h4433_2211_4433_2211, 64'h0807_0605_0403_0201};
`else
    logic [63:0] sv_exp  [4] = '{64'h1010_1010_1010_1010, 64'hAABB_AABB_AABB_AABB,
                                 64'h1122_3344_1122_3344, 64'h0102_0304_0506_0708};
`endif

    initial begin
        rst = 1'b1;
        ic_valid = 0; ld_valid = 0; st_valid = 0;
        ic_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; st_size = '0;
        if_done = 0; ld_done = 0; st_done = 0; ack = 0;
        tick();
        tick();
        chk("rst_val",      {63'd0, val}, 64'd0);
        chk("rst_rqtype",   {59'd0, rqtype}, 64'd0);
        chk("rst_size",     {61'd0, size}, 64'd0);
        chk("rst_address",  {24'd0, address}, 64'd0);
        chk("rst_data",     data, 64'd0);
        chk("rst_nc",       {63'd0, nc}, 64'd0);
        chk("rst_threadid", {63'd0, threadid}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        rst = 1'b0;
        tick();

        // Ifill with a 3-cycle ack delay.
        ic_valid = 1; ic_addr = 40'h80_0000_1234;
        tick();
        ic_valid = 0;
        chk("if_not_yet", {63'd0, val}, 64'd0);
        tick();
        chk("if_val_c1",  {63'd0, val}, 64'd1);
        chk("if_rqtype",  {59'd0, rqtype}, {59'd0, C_IMISS});
        chk("if_size",    {61'd0, size}, 64'd6);
        chk("if_address", {24'd0, address}, 64'h80_0000_1220);
        chk("if_data",    data, 64'd0);
        tick();
        chk("if_val_c2",  {63'd0, val}, 64'd1);
        tick();
        chk("if_val_c3",  {63'd0, val}, 64'd1);
        ack_now();
        if_done = 1;
        tick();
        if_done = 0;

        // Retired ifill lets a second one issue.
        ic_valid = 1; ic_addr = 40'h12_3456_789F;
        tick();
        ic_valid = 0;
        tick();
        chk("if2_val",     {63'd0, val}, 64'd1);
        chk("if2_address", {24'd0, address}, 64'h12_3456_7880);
        ack_now();
        if_done = 1;
        tick();
        if_done = 0;

        // Store formatting for every size.
        for (int i = 0; i < 4; i++) begin
            st_valid = 1; st_addr = sv_addr[i]; st_data = sv_data[i]; st_size = sv_sz[i];
            tick();
            st_valid = 0;
            tick();
            chk("st_val",     {63'd0, val}, 64'd1);
            chk("st_rqtype",  {59'd0, rqtype}, {59'd0, C_STORE});
            chk("st_size",    {61'd0, size}, {61'd0, sv_msz[i]});
            chk("st_address", {24'd0, address}, {24'd0, sv_addr[i]});
            chk("st_data",    data, sv_exp[i]);
            ack_now();
            st_done = 1;
            tick();
            st_done = 0;
        end

        // ST and LD in the same cycle: ST wins, LD follows two cycles later.
        st_valid = 1; st_addr = 40'h1000; st_data = 64'h55; st_size = 2'd3;
        ld_valid = 1; ld_addr = 40'h2_0000_0ABC;
        tick();
        st_valid = 0; ld_valid = 0;
        tick();
        chk("arb_first_val",    {63'd0, val}, 64'd1);
        chk("arb_first_rqtype", {59'd0, rqtype}, {59'd0, C_STORE});
        ack_now();
        tick();
        chk("arb_second_val",    {63'd0, val}, 64'd1);
        chk("arb_second_rqtype", {59'd0, rqtype}, {59'd0, C_LOAD});
        chk("ld_address",        {24'd0, address}, 64'h2_0000_0AB0);
        chk("ld_size",           {61'd0, size}, 64'd5);
        chk("ld_data",           data, 64'd0);
        ack_now();
        st_done = 1; ld_done = 1;
        tick();
        st_done = 0; ld_done = 0;

        // ld_done and a new LD in the same cycle is legal.
        ld_valid = 1; ld_addr = 40'h3000;
        tick();
        ld_valid = 0;
        tick();
        chk("ld_a_val", {63'd0, val}, 64'd1);
        ack_now();
        ld_done = 1; ld_valid = 1; ld_addr = 40'h3010;
        tick();
        ld_done = 0; ld_valid = 0;
        chk("same_cycle_no_ovf", {63'd0, overflow}, 64'd0);
        tick();
        chk("ld_b_val",     {63'd0, val}, 64'd1);
        chk("ld_b_address", {24'd0, address}, 64'h3010);
        ack_now();
        ld_done = 1;
        tick();
        ld_done = 0;

        // Second LD while the first is outstanding.
        ld_valid = 1; ld_addr = 40'h4000;
        tick();
        ld_valid = 0;
        tick();
        chk("ovf_ld_val", {63'd0, val}, 64'd1);
        ack_now();
        ld_valid = 1; ld_addr = 40'h5000;
        tick();
        ld_valid = 0;
        chk("ovf_set", {63'd0, overflow}, 64'd1);
        tick();
        tick();
        chk("ovf_no_issue", {63'd0, val}, 64'd0);
        ld_done = 1;
        tick();
        ld_done = 0;
        tick();
        tick();
        chk("ovf_dropped", {63'd0, val}, 64'd0);
        chk("ovf_sticky",  {63'd0, overflow}, 64'd1);

        // Reset in the middle of a request.
        ic_valid = 1; ic_addr = 40'h6000;
        tick();
        ic_valid = 0;
        tick();
        chk("rstreq_val", {63'd0, val}, 64'd1);
        ld_valid = 1; ld_addr = 40'h7000;
        tick();
        ld_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("rstreq_val_drop", {63'd0, val}, 64'd0);
        chk("rstreq_ovf_clr",  {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstreq_quiet", {63'd0, val}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
